// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and byte-lane helper functions for the
// data-memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    WR_NONE = 2'b00,
    WR_SB   = 2'b01,
    WR_SH   = 2'b10,
    WR_SW   = 2'b11
  } wr_op_e;

  typedef enum logic [2:0] {
    RD_NONE = 3'b000,
    RD_LB   = 3'b001,
    RD_LH   = 3'b010,
    RD_LW   = 3'b011,
    RD_LBU  = 3'b100,
    RD_LHU  = 3'b101
  } rd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam logic [2:0] RD_LAST_LEGAL = RD_LHU;

  function automatic logic [3:0] lane_mask(input logic [1:0] wr, input logic [1:0] off);
    case (wr)
      WR_SB:   return 4'b0001 << off;
      WR_SH:   return off[1] ? 4'b1100 : 4'b0011;
      WR_SW:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] rd, input logic [31:0] word,
                                              input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (rd)
      RD_LB:   return {{24{b[7]}}, b};
      RD_LH:   return {{16{h[15]}}, h};
      RD_LW:   return word;
      RD_LBU:  return {24'b0, b};
      RD_LHU:  return {16'b0, h};
      default: return 32'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// CPU-side request/response bundle of the data-memory controller.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  mem_write;
  logic [2:0]  mem_read;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        stall;

  modport master (
    output req_valid, mem_write, mem_read, addr, wdata,
    input  req_ready, resp_valid, rdata, err, stall
  );

  modport slave (
    input  req_valid, mem_write, mem_read, addr, wdata,
    output req_ready, resp_valid, rdata, err, stall
  );
endinterface

// File: rtl/dmem_lane_fmt.sv
// Combinational byte-lane formatter: store merge/byte enables, load extension
// and alignment checking for one 32-bit RAM word.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  mem_write_i,
  input  logic [2:0]  mem_read_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] ram_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic        wr_mis;
  logic        rd_mis;
  logic [31:0] wrep;

  always_comb begin
    wr_mis = ((mem_write_i == WR_SH) && off_i[0]) ||
             ((mem_write_i == WR_SW) && (off_i != 2'b00));
    rd_mis = (((mem_read_i == RD_LH) || (mem_read_i == RD_LHU)) && off_i[0]) ||
             ((mem_read_i == RD_LW) && (off_i != 2'b00));

    // Store data is replicated across lanes so the byte enables alone pick the target.
    case (mem_write_i)
      WR_SB:   wrep = {4{wdata_i[7:0]}};
      WR_SH:   wrep = {2{wdata_i[15:0]}};
      default: wrep = wdata_i;
    endcase

    be_o = wr_mis ? 4'b0000 : lane_mask(mem_write_i, off_i);
    for (int i = 0; i < 4; i++) begin
      wword_o[8*i +: 8] = be_o[i] ? wrep[8*i +: 8] : ram_word_i[8*i +: 8];
    end

    rdata_o    = rd_mis ? 32'b0 : load_extend(mem_read_i, ram_word_i, off_i);
    misalign_o = wr_mis || rd_mis;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request FSM with programmable wait
// states in front of a word-organised RAM array with a debug read port.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          ADDR_W   = 7,
  parameter int unsigned LATENCY  = 0,
  parameter              INIT_HEX = ""
) (
  input  logic              clk,
  input  logic              rst,
  dmem_if.slave             bus,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_data
);

  localparam logic [3:0] WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  logic [31:0]       mem_q [2**ADDR_W];

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [1:0]        wr_q;
  logic [2:0]        rd_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              accept;
  logic [31:0]       ram_word;
  logic [3:0]        be;
  logic [31:0]       wword;
  logic [31:0]       fmt_rdata;
  logic              misalign;
  logic              rd_illegal;
  logic              both_ops;
  logic              bad_op;
  logic              do_store;
  logic              unused_addr;

  assign unused_addr = ^bus.addr[31:ADDR_W+2];

  assign accept = bus.req_valid && req_ready_q &&
                  ((bus.mem_write != 2'b00) || (bus.mem_read != 3'b000));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      wr_q         <= 2'b00;
      rd_q         <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= 32'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            wr_q        <= bus.mem_write;
            rd_q        <= bus.mem_read;
            addr_q      <= bus.addr[ADDR_W+1:0];
            wdata_q     <= bus.wdata;
            cnt_q       <= WAIT_LOAD;
            req_ready_q <= 1'b0;
            if (LATENCY > 0) begin
              state_q <= ST_WAIT;
            end else begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
        default: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign ram_word = mem_q[addr_q[ADDR_W+1:2]];

  dmem_lane_fmt u_fmt (
    .mem_write_i (wr_q),
    .mem_read_i  (rd_q),
    .off_i       (addr_q[1:0]),
    .wdata_i     (wdata_q),
    .ram_word_i  (ram_word),
    .be_o        (be),
    .wword_o     (wword),
    .rdata_o     (fmt_rdata),
    .misalign_o  (misalign)
  );

  // A combined store+load still performs the store; an illegal load code blocks it.
  assign rd_illegal = rd_q > RD_LAST_LEGAL;
  assign both_ops   = (wr_q != 2'b00) && (rd_q != 3'b000);
  assign bad_op     = misalign || both_ops || rd_illegal;
  assign do_store   = (state_q == ST_RESP) && (be != 4'b0000) && !rd_illegal;

  always_ff @(posedge clk) begin
    if (!rst && do_store) begin
      mem_q[addr_q[ADDR_W+1:2]] <= wword;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.err        = (state_q == ST_RESP) && bad_op;
  assign bus.rdata      = ((state_q == ST_RESP) && !bad_op) ? fmt_rdata : 32'b0;
  assign bus.stall      = bus.req_valid && (!req_ready_q || (state_q == ST_IDLE));
  assign dbg_data       = mem_q[dbg_addr];

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: three instances (LATENCY 0, 3, 2) driven from
// a vector table plus hand-written reset-abort, ignore and commit-cycle sequences.
module tb_dmem_ctrl;

  typedef struct {
    int          dut;
    logic [1:0]  wr;
    logic [2:0]  rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] expRdata;
    logic        expErr;
    int          expLat;
    logic [6:0]  dbgIdx;
    logic [31:0] expDbg;
  } vec_t;

  logic        clk;
  logic [2:0]  rstVec;
  logic [2:0]  reqValid;
  logic [1:0]  memWrite;
  logic [2:0]  memRead;
  logic [31:0] addrIn;
  logic [31:0] wdataIn;
  logic [6:0]  dbgAddr;

  logic [2:0]  reqReady;
  logic [2:0]  respValid;
  logic [2:0]  errArr;
  logic [2:0]  stallArr;
  logic [31:0] rdataArr [3];
  logic [31:0] dbgData  [3];

  int compared = 0;
  int failed   = 0;

  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gDut
    dmem_if bus ();

    assign bus.req_valid = reqValid[g];
    assign bus.mem_write = memWrite;
    assign bus.mem_read  = memRead;
    assign bus.addr      = addrIn;
    assign bus.wdata     = wdataIn;
    assign reqReady[g]   = bus.req_ready;
    assign respValid[g]  = bus.resp_valid;
    assign errArr[g]     = bus.err;
    assign stallArr[g]   = bus.stall;
    assign rdataArr[g]   = bus.rdata;

    dmem_ctrl #(
      .ADDR_W   (7),
      .LATENCY  ((g == 0) ? 0 : ((g == 1) ? 3 : 2)),
      .INIT_HEX ("")
    ) dut (
      .clk      (clk),
      .rst      (rstVec[g]),
      .bus      (bus),
      .dbg_addr (dbgAddr),
      .dbg_data (dbgData[g])
    );
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // One full access: present at a negedge, accepted on the next edge, then
  // watched at each negedge until resp_valid (bounded).
  task automatic applyStimulus(input int dut, input logic [1:0] wr, input logic [2:0] rd,
                               input logic [31:0] a, input logic [31:0] d,
                               output int lat, output int readyLow, output logic stallOk,
                               output logic [31:0] gotRdata, output logic gotErr,
                               output logic [31:0] dbgAtResp);
    @(negedge clk);
    memWrite      = wr;
    memRead       = rd;
    addrIn        = a;
    wdataIn       = d;
    reqValid[dut] = 1'b1;
    lat       = -1;
    readyLow  = 0;
    stallOk   = 1'b1;
    gotRdata  = 32'b0;
    gotErr    = 1'b0;
    dbgAtResp = 32'b0;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!reqReady[dut]) readyLow++;
      if (!stallArr[dut]) stallOk = 1'b0;
      if (respValid[dut]) begin
        lat       = c;
        gotRdata  = rdataArr[dut];
        gotErr    = errArr[dut];
        dbgAtResp = dbgData[dut];
        break;
      end
    end
    reqValid[dut] = 1'b0;
    memWrite      = 2'b00;
    memRead       = 3'b000;
    if (lat < 0) begin
      compared++;
      failed++;
      $display("[TB] FAIL timeout dut%0d: got no resp_valid, expected one within 40 cycles", dut);
    end
  endtask

  initial begin
    int          lat;
    int          readyLow;
    int          bad;
    logic        stallOk;
    logic [31:0] gotRdata;
    logic        gotErr;
    logic [31:0] dbgAtResp;

    rstVec   = 3'b111;
    reqValid = 3'b000;
    memWrite = 2'b00;
    memRead  = 3'b000;
    addrIn   = 32'b0;
    wdataIn  = 32'b0;
    dbgAddr  = 7'd0;

    // dut, wr, rd, addr, wdata, expRdata, expErr, expLat, dbgIdx, expDbg
    vecs.push_back('{0, 2'b11, 3'b000, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 1, 7'd4, 32'hDEADBEEF});
    vecs.push_back('{0, 2'b00, 3'b011, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 1, 7'd4, 32'hDEADBEEF});
    vecs.push_back('{0, 2'b01, 3'b000, 32'h11,  32'h00000080, 32'h0,        1'b0, 1, 7'd4, 32'hDEAD80EF});
    vecs.push_back('{0, 2'b00, 3'b001, 32'h11,  32'h0,        32'hFFFFFF80, 1'b0, 1, 7'd4, 32'hDEAD80EF});
    vecs.push_back('{0, 2'b00, 3'b100, 32'h11,  32'h0,        32'h00000080, 1'b0, 1, 7'd4, 32'hDEAD80EF});
    vecs.push_back('{0, 2'b11, 3'b000, 32'h13,  32'h11111111, 32'h0,        1'b1, 1, 7'd4, 32'hDEAD80EF});
    vecs.push_back('{0, 2'b00, 3'b101, 32'h01,  32'h0,        32'h0,        1'b1, 1, 7'd4, 32'hDEAD80EF});
    vecs.push_back('{0, 2'b11, 3'b000, 32'h200, 32'hA5A5A5A5, 32'h0,        1'b0, 1, 7'd0, 32'hA5A5A5A5});
    vecs.push_back('{0, 2'b00, 3'b101, 32'h02,  32'h0,        32'h0000A5A5, 1'b0, 1, 7'd0, 32'hA5A5A5A5});
    vecs.push_back('{0, 2'b00, 3'b010, 32'h00,  32'h0,        32'hFFFFA5A5, 1'b0, 1, 7'd0, 32'hA5A5A5A5});
    vecs.push_back('{0, 2'b11, 3'b011, 32'h00,  32'h01020304, 32'h0,        1'b1, 1, 7'd0, 32'h01020304});
    vecs.push_back('{0, 2'b10, 3'b000, 32'h02,  32'h1234CAFE, 32'h0,        1'b0, 1, 7'd0, 32'hCAFE0304});
    vecs.push_back('{0, 2'b00, 3'b001, 32'h03,  32'h0,        32'hFFFFFFCA, 1'b0, 1, 7'd0, 32'hCAFE0304});
    vecs.push_back('{0, 2'b00, 3'b110, 32'h00,  32'h0,        32'h0,        1'b1, 1, 7'd0, 32'hCAFE0304});
    vecs.push_back('{0, 2'b01, 3'b111, 32'h00,  32'h0000005A, 32'h0,        1'b1, 1, 7'd0, 32'hCAFE0304});
    vecs.push_back('{0, 2'b00, 3'b011, 32'h00,  32'h0,        32'hCAFE0304, 1'b0, 1, 7'd0, 32'hCAFE0304});
    vecs.push_back('{1, 2'b11, 3'b000, 32'h10,  32'hDEAD80EF, 32'h0,        1'b0, 4, 7'd4, 32'hDEAD80EF});
    vecs.push_back('{1, 2'b00, 3'b010, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0, 4, 7'd4, 32'hDEAD80EF});
    vecs.push_back('{2, 2'b11, 3'b000, 32'h20,  32'h0BADF00D, 32'h0,        1'b0, 3, 7'd8, 32'h0BADF00D});

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("reset dut%0d req_ready", k), 32'(reqReady[k]), 32'd1);
      checkOutput($sformatf("reset dut%0d resp_valid", k), 32'(respValid[k]), 32'd0);
      checkOutput($sformatf("reset dut%0d rdata", k), rdataArr[k], 32'd0);
      checkOutput($sformatf("reset dut%0d err", k), 32'(errArr[k]), 32'd0);
      checkOutput($sformatf("reset dut%0d stall", k), 32'(stallArr[k]), 32'd0);
    end
    @(negedge clk);
    rstVec = 3'b000;

    foreach (vecs[i]) begin
      dbgAddr = vecs[i].dbgIdx;
      applyStimulus(vecs[i].dut, vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].d,
                    lat, readyLow, stallOk, gotRdata, gotErr, dbgAtResp);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d rdata", i), gotRdata, vecs[i].expRdata);
      checkOutput($sformatf("v%0d err", i), 32'(gotErr), 32'(vecs[i].expErr));
      checkOutput($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].expLat));
      checkOutput($sformatf("v%0d ready-low cycles", i), 32'(readyLow), 32'(vecs[i].expLat));
      checkOutput($sformatf("v%0d stall held", i), 32'(stallOk), 32'd1);
      checkOutput($sformatf("v%0d dbg_data", i), dbgData[vecs[i].dut], vecs[i].expDbg);
    end

    // Store commit is visible on the debug port only after the RESP cycle.
    dbgAddr = 7'd4;
    applyStimulus(0, 2'b11, 3'b000, 32'h10, 32'h55667788,
                  lat, readyLow, stallOk, gotRdata, gotErr, dbgAtResp);
    checkOutput("commit-cycle dbg old word", dbgAtResp, 32'hDEAD80EF);
    @(posedge clk);
    #1;
    checkOutput("post-commit dbg new word", dbgData[0], 32'h55667788);

    // A request with both op fields zero is ignored.
    @(negedge clk);
    reqValid[0] = 1'b1;
    addrIn      = 32'h10;
    bad         = 0;
    repeat (4) begin
      @(negedge clk);
      if (!reqReady[0] || respValid[0]) bad++;
    end
    reqValid[0] = 1'b0;
    checkOutput("null request ignored", 32'(bad), 32'd0);

    // Reset during the first WAIT cycle aborts the pending store.
    dbgAddr = 7'd8;
    @(negedge clk);
    memWrite    = 2'b11;
    memRead     = 3'b000;
    addrIn      = 32'h20;
    wdataIn     = 32'h12345678;
    reqValid[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort: in WAIT req_ready", 32'(reqReady[2]), 32'd0);
    rstVec[2]   = 1'b1;
    reqValid[2] = 1'b0;
    memWrite    = 2'b00;
    @(posedge clk);
    #1;
    checkOutput("abort: req_ready", 32'(reqReady[2]), 32'd1);
    checkOutput("abort: resp_valid", 32'(respValid[2]), 32'd0);
    checkOutput("abort: err", 32'(errArr[2]), 32'd0);
    checkOutput("abort: rdata", rdataArr[2], 32'd0);
    @(negedge clk);
    rstVec[2] = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (respValid[2]) bad++;
    end
    checkOutput("abort: no resp_valid", 32'(bad), 32'd0);
    checkOutput("abort: word 8 unchanged", dbgData[2], 32'h0BADF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
